// File: rtl/nes_cart_pkg.sv
// rtl/nes_cart_pkg.sv - shared types and constants for the iNES cartridge loader
package nes_cart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_TRAINER,
    ST_PRG,
    ST_CHR,
    ST_DONE,
    ST_ERR
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_MAGIC   = 2'd1,
    ERR_SIZE    = 2'd2,
    ERR_FEATURE = 2'd3
  } err_code_t;

  localparam int CFG_PRG32K_BIT = 33;
  localparam int CFG_MIRR_BIT   = 16;

  localparam int PRG_BANK_BYTES = 16384;
  localparam int CHR_BANK_BYTES = 8192;
  localparam int TRAINER_BYTES  = 512;
  localparam int HDR_BYTES      = 16;

  // "NES" followed by MS-DOS EOF
  function automatic logic [7:0] magic_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h4E;
      2'd1:    return 8'h45;
      2'd2:    return 8'h53;
      default: return 8'h1A;
    endcase
  endfunction

endpackage

// File: rtl/nes_ines_hdr_check.sv
// rtl/nes_ines_hdr_check.sv - combinational iNES header validation
// Optional feature macro: NES_LOADER_TRAINER_EN (trainer accepted instead of rejected)
module nes_ines_hdr_check
  import nes_cart_pkg::*;
#(
  parameter int MAX_PRG_BANKS = 2,
  parameter int MAX_CHR_BANKS = 1
) (
  input  logic [7:0] prg_banks,
  input  logic [7:0] chr_banks,
  input  logic [3:0] mapper_lo,
  input  logic [3:0] mapper_hi,
  input  logic       trainer,
  output logic       ok,
  output logic       skip_trainer,
  output logic [1:0] err_code
);

  localparam logic [7:0] PRG_MAX = 8'(MAX_PRG_BANKS);
  localparam logic [7:0] CHR_MAX = 8'(MAX_CHR_BANKS);

  always_comb begin
    ok           = 1'b0;
    skip_trainer = 1'b0;
    err_code     = ERR_NONE;
    if (prg_banks == 8'd0 || prg_banks > PRG_MAX || chr_banks > CHR_MAX) begin
      err_code = ERR_SIZE;
    end else if ((mapper_lo | mapper_hi) != 4'd0) begin
      err_code = ERR_FEATURE;
`ifdef NES_LOADER_TRAINER_EN
    end else begin
      ok           = 1'b1;
      skip_trainer = trainer;
    end
`else
    end else if (trainer) begin
      err_code = ERR_FEATURE;
    end else begin
      ok = 1'b1;
    end
`endif
  end

endmodule

// File: rtl/nes_cart_loader.sv
// rtl/nes_cart_loader.sv - iNES byte-stream loader driving the cartridge PRG/CHR write bus
// Optional feature macro: NES_LOADER_TRAINER_EN (512-byte trainer skipped before PRG)
module nes_cart_loader
  import nes_cart_pkg::*;
#(
  parameter int MAX_PRG_BANKS = 2,
  parameter int MAX_CHR_BANKS = 1
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        start_in,
  input  logic [7:0]  rx_data_in,
  input  logic        rx_valid_in,
  output logic        rx_ready_out,
  output logic [39:0] cfg_out,
  output logic        cfg_upd_out,
  output logic        prg_nce_out,
  output logic [14:0] prg_a_out,
  output logic        prg_r_nw_out,
  output logic [7:0]  prg_d_out,
  output logic [13:0] chr_a_out,
  output logic        chr_r_nw_out,
  output logic [7:0]  chr_d_out,
  output logic        busy_out,
  output logic        done_out,
  output logic        err_out,
  output logic [1:0]  err_code_out
);

  state_t     state, next_state;
  err_code_t  err_nxt;
  logic [15:0] cnt;
  logic [7:0] hdr_prg, hdr_chr, hdr_f6, hdr_f7, hdr_f8;
  logic       accept, hdr_ok, skip_trainer, magic_bad;
  logic       hdr_last, trn_last, prg_last, chr_last;
  logic [1:0] hdr_err, prg_top;

  nes_ines_hdr_check #(
    .MAX_PRG_BANKS(MAX_PRG_BANKS),
    .MAX_CHR_BANKS(MAX_CHR_BANKS)
  ) u_hdr_check (
    .prg_banks   (hdr_prg),
    .chr_banks   (hdr_chr),
    .mapper_lo   (hdr_f6[7:4]),
    .mapper_hi   (hdr_f7[7:4]),
    .trainer     (hdr_f6[2]),
    .ok          (hdr_ok),
    .skip_trainer(skip_trainer),
    .err_code    (hdr_err)
  );

  assign rx_ready_out = (state == ST_HDR) || (state == ST_TRAINER) ||
                        (state == ST_PRG) || (state == ST_CHR);
  assign busy_out     = rx_ready_out;
  assign done_out     = (state == ST_DONE);
  assign err_out      = (state == ST_ERR);
  assign accept       = rx_valid_in & rx_ready_out;

  // Only the first four header bytes are compared against the magic
  assign magic_bad = (cnt[15:2] == 14'd0) && (rx_data_in != magic_byte(cnt[1:0]));
  assign hdr_last  = (cnt[3:0] == 4'd15);
  assign trn_last  = (cnt[8:0] == 9'h1FF);
  assign prg_top   = hdr_prg[1:0] - 2'd1;
  assign prg_last  = (cnt[15:14] == prg_top) && (cnt[13:0] == 14'h3FFF);
  assign chr_last  = (cnt[12:0] == 13'h1FFF);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= ST_IDLE;
    else           state <= next_state;
  end

  always_comb begin
    next_state = state;
    err_nxt    = ERR_NONE;
    case (state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start_in) next_state = ST_HDR;
      end
      ST_HDR: begin
        if (accept) begin
          if (magic_bad) begin
            next_state = ST_ERR;
            err_nxt    = ERR_MAGIC;
          end else if (hdr_last) begin
            if (!hdr_ok) begin
              next_state = ST_ERR;
              err_nxt    = err_code_t'(hdr_err);
            end else if (skip_trainer) begin
              next_state = ST_TRAINER;
            end else begin
              next_state = ST_PRG;
            end
          end
        end
      end
      ST_TRAINER: begin
        if (accept && trn_last) next_state = ST_PRG;
      end
      ST_PRG: begin
        if (accept && prg_last) next_state = (hdr_chr == 8'd0) ? ST_DONE : ST_CHR;
      end
      ST_CHR: begin
        if (accept && chr_last) next_state = ST_DONE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cnt          <= '0;
      hdr_prg      <= '0;
      hdr_chr      <= '0;
      hdr_f6       <= '0;
      hdr_f7       <= '0;
      hdr_f8       <= '0;
      cfg_out      <= '0;
      cfg_upd_out  <= 1'b0;
      prg_nce_out  <= 1'b1;
      prg_r_nw_out <= 1'b1;
      prg_a_out    <= '0;
      prg_d_out    <= '0;
      chr_r_nw_out <= 1'b1;
      chr_a_out    <= '0;
      chr_d_out    <= '0;
      err_code_out <= '0;
    end else begin
      cfg_upd_out  <= 1'b0;
      prg_nce_out  <= 1'b1;
      prg_r_nw_out <= 1'b1;
      chr_r_nw_out <= 1'b1;

      // Every phase change restarts the byte counter; entering ERR latches the cause
      if (next_state != state) begin
        cnt          <= '0;
        err_code_out <= err_nxt;
      end else if (accept) begin
        cnt <= cnt + 16'd1;
      end

      if (accept) begin
        case (state)
          ST_HDR: begin
            case (cnt[3:0])
              4'd4:    hdr_prg <= rx_data_in;
              4'd5:    hdr_chr <= rx_data_in;
              4'd6:    hdr_f6  <= rx_data_in;
              4'd7:    hdr_f7  <= rx_data_in;
              4'd8:    hdr_f8  <= rx_data_in;
              default: ;
            endcase
            if (next_state == ST_PRG || next_state == ST_TRAINER) begin
              cfg_out     <= {hdr_prg, hdr_chr, hdr_f6, hdr_f7, hdr_f8};
              cfg_upd_out <= 1'b1;
            end
          end
          ST_PRG: begin
            prg_nce_out  <= 1'b0;
            prg_r_nw_out <= 1'b0;
            prg_a_out    <= cnt[14:0];
            prg_d_out    <= rx_data_in;
          end
          ST_CHR: begin
            chr_r_nw_out <= 1'b0;
            chr_a_out    <= cnt[13:0];
            chr_d_out    <= rx_data_in;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nes_cart_loader.sv
// tb/tb_nes_cart_loader.sv - randomized self-checking bench for nes_cart_loader
// Honours NES_LOADER_TRAINER_EN when the design is built with it.
module tb_nes_cart_loader;

  localparam int IMG_MAX = 40000;
`ifdef NES_LOADER_TRAINER_EN
  localparam bit TR_EN = 1'b1;
`else
  localparam bit TR_EN = 1'b0;
`endif

  logic        clk_in = 1'b0;
  logic        rst_n_in, start_in, rx_valid_in;
  logic [7:0]  rx_data_in;
  logic        rx_ready_out, cfg_upd_out, prg_nce_out, prg_r_nw_out, chr_r_nw_out;
  logic        busy_out, done_out, err_out;
  logic [39:0] cfg_out;
  logic [14:0] prg_a_out;
  logic [13:0] chr_a_out;
  logic [7:0]  prg_d_out, chr_d_out;
  logic [1:0]  err_code_out;

  always #5 clk_in = ~clk_in;

  nes_cart_loader dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .start_in(start_in),
    .rx_data_in(rx_data_in), .rx_valid_in(rx_valid_in), .rx_ready_out(rx_ready_out),
    .cfg_out(cfg_out), .cfg_upd_out(cfg_upd_out),
    .prg_nce_out(prg_nce_out), .prg_a_out(prg_a_out), .prg_r_nw_out(prg_r_nw_out),
    .prg_d_out(prg_d_out), .chr_a_out(chr_a_out), .chr_r_nw_out(chr_r_nw_out),
    .chr_d_out(chr_d_out), .busy_out(busy_out), .done_out(done_out),
    .err_out(err_out), .err_code_out(err_code_out)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Image under test and the reference model of what it must produce
  logic [7:0] img [0:IMG_MAX-1];
  int  img_len;
  logic [7:0] magic [0:3] = '{8'h4E, 8'h45, 8'h53, 8'h1A};
  int  nx_limit, nx_code, nx_t, nx_p, nx_c;
  bit  nx_ok;
  int  m_limit, m_code, m_t, m_p, m_c;
  bit  m_ok, run;
  int  n_acc;
  bit  pend_prg, pend_chr, pend_cfg;
  int  pend_addr;
  logic [7:0]  pend_data;
  int  prg_wr_cnt, chr_wr_cnt, upd_cnt;
  logic [39:0] last_cfg;
  logic [14:0] last_prg_a;
  logic [7:0]  first_prg_d;

  task automatic make_img(input int prg, input int chr, input logic [7:0] f6, input logic [7:0] f7);
    int body;
    for (int i = 0; i < 16; i++) img[i] = 8'h00;
    for (int i = 0; i < 4; i++) img[i] = magic[i];
    img[4] = prg[7:0];
    img[5] = chr[7:0];
    img[6] = f6;
    img[7] = f7;
    body = (f6[2] ? 512 : 0) + prg * 16384 + chr * 8192 + 4;
    img_len = (16 + body > IMG_MAX) ? IMG_MAX : 16 + body;
    for (int i = 16; i < img_len; i++) img[i] = 8'($urandom);
  endtask

  // Expected outcome of loading img, straight from the header rules
  task automatic predict();
    nx_ok = 1'b0; nx_code = 0; nx_t = 0;
    nx_p = img[4] * 16384;
    nx_c = img[5] * 8192;
    for (int i = 0; i < 4; i++) begin
      if (img[i] != magic[i]) begin
        nx_limit = i + 1;
        nx_code  = 1;
        return;
      end
    end
    nx_limit = 16;
    if (img[4] < 1 || img[4] > 2 || img[5] > 1) nx_code = 2;
    else if (img[6][7:4] != 0 || img[7][7:4] != 0) nx_code = 3;
    else if (img[6][2] && !TR_EN) nx_code = 3;
    else begin
      nx_ok    = 1'b1;
      nx_t     = img[6][2] ? 512 : 0;
      nx_limit = 16 + nx_t + nx_p + nx_c;
    end
  endtask

  always @(negedge clk_in) begin
    bit loading, fin;
    int k, p0;
    if (!rst_n_in) begin
      run = 1'b0; pend_prg = 1'b0; pend_chr = 1'b0; pend_cfg = 1'b0;
    end else begin
      loading = run && (n_acc < m_limit);
      fin     = run && (n_acc >= m_limit);
      chk("rx_ready", rx_ready_out, loading);
      chk("busy", busy_out, loading);
      chk("done", done_out, fin && m_ok);
      chk("err", err_out, fin && !m_ok);
      chk("err_code", err_code_out, (fin && !m_ok) ? m_code : 0);
      chk("cfg_upd", cfg_upd_out, pend_cfg);
      if (pend_cfg) begin
        chk("cfg", cfg_out, {img[4], img[5], img[6], img[7], img[8]});
        last_cfg = cfg_out;
      end
      if (cfg_upd_out) upd_cnt++;
      chk("prg_nce", prg_nce_out, !pend_prg);
      chk("prg_r_nw", prg_r_nw_out, !pend_prg);
      if (pend_prg) begin
        chk("prg_a", prg_a_out, pend_addr);
        chk("prg_d", prg_d_out, pend_data);
      end
      if (!prg_nce_out) begin
        if (prg_wr_cnt == 0) first_prg_d = prg_d_out;
        prg_wr_cnt++;
        last_prg_a = prg_a_out;
      end
      chk("chr_r_nw", chr_r_nw_out, !pend_chr);
      if (pend_chr) begin
        chk("chr_a", chr_a_out, pend_addr);
        chk("chr_d", chr_d_out, pend_data);
      end
      if (!chr_r_nw_out) chr_wr_cnt++;

      pend_prg = 1'b0; pend_chr = 1'b0; pend_cfg = 1'b0;
      if (run && rx_valid_in && rx_ready_out) begin
        k = n_acc;
        if (m_ok) begin
          p0 = 16 + m_t;
          if (k == 15) pend_cfg = 1'b1;
          if (k >= p0 && k < p0 + m_p) begin
            pend_prg = 1'b1; pend_addr = k - p0;
          end else if (k >= p0 + m_p) begin
            pend_chr = 1'b1; pend_addr = k - p0 - m_p;
          end
          pend_data = img[k];
        end
        n_acc++;
      end
      if (start_in && !loading) begin
        run = 1'b1; n_acc = 0;
        m_limit = nx_limit; m_code = nx_code; m_ok = nx_ok;
        m_t = nx_t; m_p = nx_p; m_c = nx_c;
        prg_wr_cnt = 0; chr_wr_cnt = 0; upd_cnt = 0;
      end
    end
  end

  // Streams img with random valid gaps (gap of 8 chance idle); stop_at > 0 abandons early
  task automatic run_load(input int gap, input int stop_at, input int budget);
    int idx = 0, cyc = 0, tail = 0;
    logic acc, fin;
    predict();
    start_in = 1'b1;
    @(posedge clk_in); #1;
    start_in = 1'b0;
    while (1) begin
      rx_valid_in = (idx < img_len) && ($urandom_range(0, 7) >= gap);
      rx_data_in  = (idx < img_len) ? img[idx] : 8'h00;
      @(negedge clk_in);
      acc = rx_valid_in & rx_ready_out;
      fin = done_out | err_out;
      @(posedge clk_in); #1;
      if (acc) idx++;
      cyc++;
      if (stop_at > 0 && idx >= stop_at) break;
      if (fin) tail++;
      if (tail >= 4) break;
      if (cyc > budget) begin
        chk("load_timeout", 1'b1, 1'b0);
        break;
      end
    end
    rx_valid_in = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_nce"}, prg_nce_out, 1'b1);
    chk({tag, "_prg_rnw"}, prg_r_nw_out, 1'b1);
    chk({tag, "_chr_rnw"}, chr_r_nw_out, 1'b1);
    chk({tag, "_ready"}, rx_ready_out, 1'b0);
    chk({tag, "_busy"}, busy_out, 1'b0);
    chk({tag, "_cfg"}, cfg_out, 40'h0);
    chk({tag, "_upd"}, cfg_upd_out, 1'b0);
    chk({tag, "_addr"}, {prg_a_out, chr_a_out}, 29'h0);
    chk({tag, "_data"}, {prg_d_out, chr_d_out}, 16'h0);
    chk({tag, "_flags"}, {done_out, err_out, err_code_out}, 4'h0);
  endtask

  initial begin
    rst_n_in = 1'b0; start_in = 1'b0; rx_valid_in = 1'b0; rx_data_in = 8'h00;
    repeat (3) @(posedge clk_in);
    #1 check_reset_outputs("reset");
    rst_n_in = 1'b1;
    repeat (2) @(posedge clk_in);
    #1;

    // 16K PRG + 8K CHR, vertical mirroring, random gaps
    make_img(1, 1, 8'h01, 8'h00);
    run_load(1, 0, 40000);
    chk("t1_done", done_out, 1'b1);
    chk("t1_cfg", last_cfg, 40'h01_01_01_00_00);
    chk("t1_upd_cnt", upd_cnt, 1);
    chk("t1_prg_cnt", prg_wr_cnt, 16384);
    chk("t1_chr_cnt", chr_wr_cnt, 8192);

    // 32K PRG, CHR-RAM
    make_img(2, 0, 8'h00, 8'h00);
    run_load(0, 0, 40000);
    chk("t2_done", done_out, 1'b1);
    chk("t2_prg32k", last_cfg[33], 1'b1);
    chk("t2_last_a", last_prg_a, 15'h7FFF);
    chk("t2_prg_cnt", prg_wr_cnt, 32768);
    chk("t2_chr_cnt", chr_wr_cnt, 0);

    // Bad magic at byte 2
    make_img(1, 1, 8'h01, 8'h00);
    img[2] = 8'h54;
    run_load(0, 0, 200);
    chk("t3_code", {err_out, err_code_out}, 3'b1_01);
    chk("t3_ready", rx_ready_out, 1'b0);
    chk("t3_writes", upd_cnt + prg_wr_cnt + chr_wr_cnt, 0);

    // Three PRG banks: size error
    make_img(3, 0, 8'h00, 8'h00);
    run_load(2, 0, 200);
    chk("t4_code", {err_out, err_code_out}, 3'b1_10);
    chk("t4_writes", upd_cnt + prg_wr_cnt + chr_wr_cnt, 0);

    // Non-zero mapper nibble
    make_img(1, 1, 8'h10, 8'h00);
    run_load(0, 0, 200);
    chk("t5_code", {err_out, err_code_out}, 3'b1_11);
    chk("t5_writes", upd_cnt + prg_wr_cnt + chr_wr_cnt, 0);

    // Reset in the middle of PRG with gappy stream
    make_img(2, 1, 8'h01, 8'h00);
    run_load(3, 16 + 300, 4000);
    chk("t6_mid_busy", busy_out, 1'b1);
    rst_n_in = 1'b0;
    #1 check_reset_outputs("midrst");
    @(posedge clk_in); #1;
    rst_n_in = 1'b1;
    @(posedge clk_in); #1;

    // Restart after reset loads cleanly
    make_img(1, 0, 8'h00, 8'h00);
    run_load(1, 0, 40000);
    chk("t7_done", done_out, 1'b1);
    chk("t7_prg_cnt", prg_wr_cnt, 16384);
    chk("t7_last_a", last_prg_a, 15'h3FFF);

    // Trainer flag
    make_img(1, 0, 8'h04, 8'h00);
    if (TR_EN) begin
      run_load(0, 528 + 64, 2000);
      @(negedge clk_in);
      chk("t8_prg_started", prg_wr_cnt > 0, 1'b1);
      chk("t8_prg_byte0", first_prg_d, img[528]);
      @(posedge clk_in); #1;
      rst_n_in = 1'b0;
      @(posedge clk_in); #1;
      rst_n_in = 1'b1;
    end else begin
      run_load(0, 0, 200);
      chk("t8_code", {err_out, err_code_out}, 3'b1_11);
      chk("t8_writes", upd_cnt + prg_wr_cnt, 0);
    end
    repeat (2) @(posedge clk_in);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
